sample_averager: RTL and testbench
==================================

Name: sample_averager

Overview:
- Downstream consumer of the per-window tree sum produced by the summing stage.
- Captures the window total, divides it by NUM_SAMPLES with a bit-serial restoring divider, optionally rounds, and compares the result against a threshold.
- Presents the mean and the compare flag on a valid/ready output handshake toward the classification logic.

Parameters:
- NUM_SAMPLES, 2, samples per window and the divisor; must be >= 2.
- DATA_SIZE, 4, width of one sample and of the mean output.
- ROUND, 0, 0 = truncate; 1 = round half up.
- SUM_W (derived, not overridable), $clog2(NUM_SAMPLES)+DATA_SIZE, width of the input sum.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  synchronous active-high reset.
- sumIn  input  SUM_W  window total.
- sumValid  input  1  single-cycle pulse; sumIn is valid in that cycle.
- threshold  input  DATA_SIZE  compare level; sampled with sumIn.
- avg  output  DATA_SIZE  mean of the window.
- remainder  output  $clog2(NUM_SAMPLES)  sumIn mod NUM_SAMPLES.
- above  output  1  1 when avg >= captured threshold.
- outValid  output  1  result available.
- outReady  input  1  consumer accepts the result.
- busy  output  1  state != IDLE.
- dropped  output  1  sticky; a sumValid was lost.

Behaviour:
- Reset (rst high at an edge):
  - state goes to IDLE.
  - avg, remainder, above, outValid, busy, dropped and all internal registers go to 0.
  - Reset asserted mid-division or mid-DONE discards the operation; no outValid follows.
- FSM states: IDLE, DIVIDE, DONE.
- IDLE:
  - On sumValid: capture sumIn into the dividend register and threshold into the threshold register, clear the partial remainder and the counter, then go to DIVIDE.
- DIVIDE: one quotient bit per cycle, MSB first, for exactly SUM_W cycles.
  - Each cycle: shift the partial remainder left, bringing in the next dividend bit.
  - If the partial remainder >= NUM_SAMPLES, subtract NUM_SAMPLES and set the quotient bit to 1; otherwise set it to 0.
  - Partial remainder register is $clog2(NUM_SAMPLES)+1 bits, so the shift never overflows.
  - After the SUM_W-th cycle: register the outputs and go to DONE.
- Output computation (registered on entry to DONE):
  - q = SUM_W-bit quotient; r = final remainder.
  - If ROUND=1 and 2*r >= NUM_SAMPLES, q = q + 1.
  - If q > 2^DATA_SIZE-1, avg saturates to all ones; otherwise avg = q[DATA_SIZE-1:0]. Only out-of-range sums reach saturation.
  - remainder = r; this is the unrounded remainder even when ROUND=1.
  - above = (avg >= captured threshold), evaluated on the final (rounded and saturated) avg.
- Latency: sumValid in cycle t gives outValid high from cycle t+SUM_W+1.
- DONE:
  - outValid is held high; avg, remainder and above stay stable until the handshake.
  - Handshake: outValid && outReady at an edge completes the transfer.
  - If sumValid is also high in that cycle, the new sum is captured and the FSM goes straight to DIVIDE; otherwise it goes to IDLE.
  - outValid drops the cycle after the handshake.
- Lost inputs:
  - sumValid in DIVIDE, or in DONE without a completing handshake, is ignored.
  - In that case dropped is set and stays high until rst. The in-flight result is unaffected.
- outReady while outValid is low has no effect.
- busy is high in DIVIDE and DONE.

Test Plan:
- All tests use NUM_SAMPLES=4, DATA_SIZE=4, ROUND=0, outReady held high unless stated.
  - sumIn=37, threshold=9 -> outValid at t+7; avg=9, remainder=1, above=1. outValid drops the next cycle and busy returns to 0.
  - sumIn=60, threshold=15 -> avg=15, remainder=0, above=1. sumIn=0, threshold=1 -> avg=0, remainder=0, above=0.
  - outReady held low 5 cycles after outValid rises -> outputs stay stable throughout. A sumValid pulse during that wait sets dropped=1 and leaves the held result unchanged.
  - Second sumValid (sumIn=8) in the same cycle as the handshake for 37 -> captured; avg=2, remainder=0 appears 7 cycles later; dropped stays 0.
- ROUND=1 cases:
  - sumIn=38 -> avg=10, remainder=2.
  - sumIn=37 -> avg=9.
  - sumIn=63 (out of range) -> avg=15 (saturated), remainder=3.
- Reset mid-operation: rst pulsed 3 cycles into DIVIDE -> all outputs 0 and no outValid afterward. A fresh sumIn=20 then yields avg=5 at the normal latency.

Source files
------------

// File: rtl/sample_averager.sv
// sample_averager: bit-serial restoring divide of a window sum by NUM_SAMPLES,
// optional rounding and saturation, threshold compare, valid/ready result.
module sample_averager #(
  parameter int NUM_SAMPLES = 2,
  parameter int DATA_SIZE = 4,
  parameter int ROUND = 0,
  localparam int SUM_W = $clog2(NUM_SAMPLES) + DATA_SIZE,
  localparam int RRW = $clog2(NUM_SAMPLES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SUM_W-1:0]     sumIn,
  input  logic                 sumValid,
  input  logic [DATA_SIZE-1:0] threshold,
  output logic [DATA_SIZE-1:0] avg,
  output logic [RRW-1:0]       remainder,
  output logic                 above,
  output logic                 outValid,
  input  logic                 outReady,
  output logic                 busy,
  output logic                 dropped
);
  localparam int RW = RRW + 1;
  localparam int CW = $clog2(SUM_W);
  localparam logic [RW-1:0] NS = RW'(NUM_SAMPLES);
  localparam logic [1:0] IDLE = 2'd0, DIVIDE = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [SUM_W-1:0] dividend, q;
  logic [RW-1:0] pr, pr_shift, rn;
  logic [CW-1:0] cnt;
  logic [DATA_SIZE-1:0] thr, avg_n;
  logic [SUM_W:0] qr;
  logic ge, rnd, start, last;
  // Quotient bits shift into the dividend register as its bits are consumed.
  always_comb begin
    pr_shift = RW'({pr, dividend[SUM_W-1]});
    ge = pr_shift >= NS;
    rn = ge ? pr_shift - NS : pr_shift;
    q = {dividend[SUM_W-2:0], ge};
    rnd = (ROUND != 0) && (2 * int'(rn) >= NUM_SAMPLES);
    qr = {1'b0, q} + (SUM_W+1)'(rnd);
    avg_n = |qr[SUM_W:DATA_SIZE] ? '1 : qr[DATA_SIZE-1:0];
    start = sumValid && (state == IDLE || (state == DONE && outReady));
    last = cnt == CW'(SUM_W - 1);
  end
  assign outValid = state == DONE;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      dividend <= '0;
      pr <= '0;
      cnt <= '0;
      thr <= '0;
      avg <= '0;
      remainder <= '0;
      above <= '0;
      dropped <= 1'b0;
    end else begin
      if (sumValid && !start) dropped <= 1'b1;
      if (start) begin
        state <= DIVIDE;
        dividend <= sumIn;
        thr <= threshold;
        pr <= '0;
        cnt <= '0;
      end else if (state == DIVIDE) begin
        dividend <= q;
        pr <= rn;
        cnt <= cnt + 1'b1;
        if (last) begin
          state <= DONE;
          avg <= avg_n;
          remainder <= RRW'(rn);
          above <= avg_n >= thr;
        end
      end else if (state == DONE && outReady) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_sample_averager.sv
// tb_sample_averager: scoreboard bench driving a truncating and a rounding instance in lockstep.
module tb_sample_averager;
  logic clk = 0, rst = 1, sum_valid = 0, out_ready = 0;
  logic [5:0] sum_in = '0;
  logic [3:0] threshold = '0;
  logic [3:0] avg0, avg1;
  logic [1:0] rem0, rem1;
  logic above0, above1, ov0, ov1, busy0, busy1, drop0, drop1;
  int errors = 0, checks = 0;
  typedef struct {logic [3:0] a0; logic [1:0] r; logic b0; logic [3:0] a1; logic b1;} exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  sample_averager #(.NUM_SAMPLES(4), .DATA_SIZE(4), .ROUND(0)) dut (
    .clk(clk), .rst(rst), .sumIn(sum_in), .sumValid(sum_valid), .threshold(threshold),
    .avg(avg0), .remainder(rem0), .above(above0), .outValid(ov0), .outReady(out_ready),
    .busy(busy0), .dropped(drop0));

  sample_averager #(.NUM_SAMPLES(4), .DATA_SIZE(4), .ROUND(1)) dut_r (
    .clk(clk), .rst(rst), .sumIn(sum_in), .sumValid(sum_valid), .threshold(threshold),
    .avg(avg1), .remainder(rem1), .above(above1), .outValid(ov1), .outReady(out_ready),
    .busy(busy1), .dropped(drop1));

  function automatic exp_t model(int s, int th);
    exp_t e;
    int q, r, qr;
    q = s / 4;
    r = s % 4;
    qr = q + ((2 * r >= 4) ? 1 : 0);
    e.a0 = 4'(q > 15 ? 15 : q);
    e.r = 2'(r);
    e.b0 = int'(e.a0) >= th;
    e.a1 = 4'(qr > 15 ? 15 : qr);
    e.b1 = int'(e.a1) >= th;
    return e;
  endfunction

  task automatic send(int s, int th);
    sum_in = 6'(s);
    threshold = 4'(th);
    sum_valid = 1;
    sb.push_back(model(s, th));
    @(posedge clk);
    #1 sum_valid = 0;
  endtask

  task automatic collect(string tag, output exp_t e);
    int n = 0;
    while (!ov0 && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    checks++;
    if (!ov0 || sb.size() == 0) begin
      errors++;
      $display("FAIL %s timeout: outValid=%0b queued=%0d", tag, ov0, sb.size());
      e = '{default: '0};
      return;
    end
    if (n != 6) begin errors++; $display("FAIL %s latency: got %0d want 6", tag, n); end
    e = sb.pop_front();
    checks += 6;
    if (avg0 !== e.a0) begin errors++; $display("FAIL %s avg: got %0d want %0d", tag, avg0, e.a0); end
    if (rem0 !== e.r) begin errors++; $display("FAIL %s remainder: got %0d want %0d", tag, rem0, e.r); end
    if (above0 !== e.b0) begin errors++; $display("FAIL %s above: got %0b want %0b", tag, above0, e.b0); end
    if (avg1 !== e.a1) begin errors++; $display("FAIL %s round avg: got %0d want %0d", tag, avg1, e.a1); end
    if (rem1 !== e.r) begin errors++; $display("FAIL %s round remainder: got %0d want %0d", tag, rem1, e.r); end
    if (above1 !== e.b1) begin errors++; $display("FAIL %s round above: got %0b want %0b", tag, above1, e.b1); end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks += 2;
    if ({avg0, rem0, above0, ov0, busy0, drop0} !== 10'b0) begin
      errors++; $display("FAIL reset outputs: got %b want 0", {avg0, rem0, above0, ov0, busy0, drop0});
    end
    if ({avg1, rem1, above1, ov1, busy1, drop1} !== 10'b0) begin
      errors++; $display("FAIL reset round outputs: got %b want 0", {avg1, rem1, above1, ov1, busy1, drop1});
    end
    rst = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    exp_t e;
    out_ready = 1;
    send(37, 9);
    collect("basic37", e);
    @(posedge clk);
    #1;
    checks++;
    if ({ov0, busy0} !== 2'b00) begin
      errors++; $display("FAIL basic release: got valid/busy=%b want 00", {ov0, busy0});
    end
  endtask

  task automatic test_values();
    exp_t e;
    int vals[4][2] = '{'{60, 15}, '{0, 1}, '{38, 0}, '{63, 0}};
    foreach (vals[i]) begin
      send(vals[i][0], vals[i][1]);
      collect($sformatf("value%0d", vals[i][0]), e);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    send(37, 9);
    collect("b2b_first", e);
    send(8, 0);
    collect("b2b_second", e);
    @(posedge clk);
    #1;
    checks++;
    if (drop0 !== 1'b0) begin errors++; $display("FAIL b2b dropped: got %0b want 0", drop0); end
  endtask

  task automatic test_hold();
    exp_t e;
    out_ready = 0;
    send(50, 12);
    collect("hold", e);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin sum_in = 6'd1; sum_valid = 1; end
      @(posedge clk);
      #1 sum_valid = 0;
      checks++;
      if ({ov0, avg0, rem0, above0} !== {1'b1, e.a0, e.r, e.b0}) begin
        errors++;
        $display("FAIL hold stable[%0d]: got %b want %b", i, {ov0, avg0, rem0, above0}, {1'b1, e.a0, e.r, e.b0});
      end
    end
    checks += 2;
    if (drop0 !== 1'b1) begin errors++; $display("FAIL hold dropped: got %0b want 1", drop0); end
    if (drop1 !== 1'b1) begin errors++; $display("FAIL hold round dropped: got %0b want 1", drop1); end
    out_ready = 1;
    @(posedge clk);
    #1;
    checks++;
    if (ov0 !== 1'b0) begin errors++; $display("FAIL hold release: got %0b want 0", ov0); end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    bit seen = 0;
    send(45, 3);
    repeat (2) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    sb.delete();
    checks++;
    if ({avg0, rem0, above0, ov0, busy0, drop0} !== 10'b0) begin
      errors++; $display("FAIL midreset outputs: got %b want 0", {avg0, rem0, above0, ov0, busy0, drop0});
    end
    repeat (12) begin
      @(posedge clk);
      #1 if (ov0) seen = 1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL midreset stray outValid: got 1 want 0"); end
    send(20, 7);
    collect("after_reset", e);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_values();
    test_back_to_back();
    test_hold();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
